xspi_phy_master: RTL and testbench

Single/dual/quad/octo-SPI master (initiator) PHY: generates SCK and CE from the system clock and shifts transaction words out on, and in from, 1/2/4/8 data lanes. It is the host-side counterpart of the xSPI slave PHY and drives it directly in board-level and loopback benches. It uses the same transaction model as the slave:
- N bits over 2^mode lanes, MSW first.
- SPI mode 0/3 timing: data changes on the SCK fall and is captured on the SCK rise.
- CE can be held across chained transactions, so command, address and data phases form one frame.

---
 rtl/xspi_phy_master.sv | 235 +++++++++++++++++++++++
 tb/tb_xspi_phy_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xspi_phy_master.sv
// xSPI master PHY: SCK/CE generation and MSW-first shifting over 1/2/4/8 lanes (SPI mode 0/3).
// Optional read dummy cycles (port txndummy_i) when XSPI_PHY_MASTER_DUMMY_EN is defined.
module xspi_phy_master #(
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int CLK_DIV          = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  output logic                        sck_o,
  output logic                        sce_o,
  input  logic [7:0]                  sio_i,
  output logic [7:0]                  sio_o,
  output logic                        sio_oe,
  input  logic                        txnvalid_i,
  output logic                        txnready_o,
  input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
  input  logic [1:0]                  txnmode_i,
  input  logic                        txndir_i,
  input  logic                        txnlast_i,
  input  logic [WORD_SIZE-1:0]        txndata_i,
`ifdef XSPI_PHY_MASTER_DUMMY_EN
  input  logic [3:0]                  txndummy_i,
`endif
  output logic [WORD_SIZE-1:0]        txndata_o,
  output logic                        txndone_o
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int AW    = CYCLE_COUNT_BITS + 3;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DES_M1 = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_MAX = CYCLE_COUNT_BITS'(WORD_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_CSS, S_LOW, S_HIGH, S_CHAIN, S_CSH, S_DESEL
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CYCLE_COUNT_BITS-1:0] cyc_q, cyc_d;
  logic [3:0]                  dum_q, dum_d;
  logic [1:0]                  mode_q, mode_d;
  logic                        dir_q, dir_d;
  logic                        last_q, last_d;
  logic [WORD_SIZE-1:0]        tx_q, tx_d;
  logic [WORD_SIZE-1:0]        rx_q, rx_d;
  logic                        sck_q, sck_d;
  logic                        sce_q, sce_d;
  logic [7:0]                  sio_q, sio_d;
  logic                        oe_q, oe_d;
  logic                        ready_q, ready_d;
  logic                        done_q, done_d;

  logic [CYCLE_COUNT_BITS-1:0] bc_c;
  logic [CYCLE_COUNT_BITS-1:0] cyc_new;
  logic [AW-1:0]               used_bits;
  logic [WORD_SIZE-1:0]        tx_new;
  logic [3:0]                  dum_new;
  logic                        accept;
  logic                        phase_end;

  function automatic logic [7:0] top_lanes(input logic [WORD_SIZE-1:0] w, input logic [1:0] m);
    case (m)
      2'd0:    top_lanes = {7'd0, w[WORD_SIZE-1]};
      2'd1:    top_lanes = {6'd0, w[WORD_SIZE-1 -: 2]};
      2'd2:    top_lanes = {4'd0, w[WORD_SIZE-1 -: 4]};
      default: top_lanes = w[WORD_SIZE-1 -: 8];
    endcase
  endfunction

  function automatic logic [WORD_SIZE-1:0] shift_in(input logic [WORD_SIZE-1:0] w,
                                                    input logic [7:0] s, input logic [1:0] m);
    case (m)
      2'd0:    shift_in = {w[WORD_SIZE-2:0], s[0]};
      2'd1:    shift_in = {w[WORD_SIZE-3:0], s[1:0]};
      2'd2:    shift_in = {w[WORD_SIZE-5:0], s[3:0]};
      default: shift_in = {w[WORD_SIZE-9:0], s[7:0]};
    endcase
  endfunction

  // Request decode: the word is left-aligned so the first cycle's lanes are always the MSBs.
  always_comb begin
    bc_c = (txnbc_i > BC_MAX) ? BC_MAX : txnbc_i;
    case (txnmode_i)
      2'd0:    cyc_new = bc_c;
      2'd1:    cyc_new = (bc_c >> 1) + CYCLE_COUNT_BITS'(bc_c[0]);
      2'd2:    cyc_new = (bc_c >> 2) + CYCLE_COUNT_BITS'(|bc_c[1:0]);
      default: cyc_new = (bc_c >> 3) + CYCLE_COUNT_BITS'(|bc_c[2:0]);
    endcase
    used_bits = AW'(cyc_new) << txnmode_i;
    tx_new    = txndata_i << (AW'(WORD_SIZE) - used_bits);
`ifdef XSPI_PHY_MASTER_DUMMY_EN
    dum_new   = txndir_i ? 4'd0 : txndummy_i;
`else
    dum_new   = 4'd0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    dum_d     = dum_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    last_d    = last_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    done_d    = 1'b0;
    accept    = txnvalid_i && ready_q;
    phase_end = (cnt_q == DIV_M1);

    case (state_q)
      S_IDLE, S_CHAIN: begin
        if (accept) begin
          cyc_d  = cyc_new;
          dum_d  = dum_new;
          mode_d = txnmode_i;
          dir_d  = txndir_i;
          last_d = txnlast_i;
          tx_d   = tx_new;
          cnt_d  = '0;
          if (cyc_new == '0) begin
            state_d = txnlast_i ? S_CSH : S_CHAIN;
            done_d  = 1'b1;
          end else begin
            state_d = (state_q == S_IDLE) ? S_CSS : S_LOW;
          end
        end
      end
      S_CSS, S_LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = (state_q == S_CSS) ? S_LOW : S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_d = '0;
          if (dum_q != 4'd0) begin
            dum_d   = dum_q - 4'd1;
            state_d = S_LOW;
          end else begin
            rx_d  = shift_in(rx_q, sio_i, mode_q);
            tx_d  = shift_in(tx_q, 8'd0, mode_q);
            cyc_d = cyc_q - CYCLE_COUNT_BITS'(1);
            if (cyc_q == CYCLE_COUNT_BITS'(1)) begin
              state_d = last_q ? S_CSH : S_CHAIN;
              done_d  = 1'b1;
            end else begin
              state_d = S_LOW;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CSH: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = S_DESEL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DESEL: begin
        if (cnt_q == DES_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pins are registered from the next state so SCK and CE never glitch.
    sce_d   = (state_d != S_IDLE) && (state_d != S_DESEL);
    sck_d   = (state_d == S_HIGH);
    ready_d = (state_d == S_IDLE) || (state_d == S_CHAIN);
    oe_d    = dir_d && ((state_d == S_CSS) || (state_d == S_LOW) || (state_d == S_HIGH));
    sio_d   = (oe_d && (dum_d == 4'd0)) ? top_lanes(tx_d, mode_d) : 8'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      dum_q   <= 4'd0;
      mode_q  <= 2'd0;
      dir_q   <= 1'b0;
      last_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      sce_q   <= 1'b0;
      sio_q   <= 8'd0;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      dum_q   <= dum_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
      sce_q   <= sce_d;
      sio_q   <= sio_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign sck_o      = sck_q;
  assign sce_o      = sce_q;
  assign sio_o      = sio_q;
  assign sio_oe     = oe_q;
  assign txnready_o = ready_q;
  assign txndata_o  = rx_q;
  assign txndone_o  = done_q;

endmodule

// File: tb/tb_xspi_phy_master.sv
// Directed bench for xspi_phy_master: frame timing, lane ordering, chaining, clamping and reset abort.
`timescale 1ns/1ps
module tb_xspi_phy_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck_o, sce_o, sio_oe, txnready_o, txndone_o;
  logic [7:0]  sio_i, sio_o;
  logic        txnvalid, txndir, txnlast;
  logic [5:0]  txnbc;
  logic [1:0]  txnmode;
  logic [31:0] txndata, txndata_o;

  always #5 clk = ~clk;

  xspi_phy_master dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sck_o      (sck_o),
    .sce_o      (sce_o),
    .sio_i      (sio_i),
    .sio_o      (sio_o),
    .sio_oe     (sio_oe),
    .txnvalid_i (txnvalid),
    .txnready_o (txnready_o),
    .txnbc_i    (txnbc),
    .txnmode_i  (txnmode),
    .txndir_i   (txndir),
    .txnlast_i  (txnlast),
    .txndata_i  (txndata),
`ifdef XSPI_PHY_MASTER_DUMMY_EN
    .txndummy_i (4'd0),
`endif
    .txndata_o  (txndata_o),
    .txndone_o  (txndone_o)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         lat, pulses;
  logic [7:0] sio_log [64];
  logic       oe_or, oe_bad, sce_low, sio_or;

  // Called at a negedge; returns at the negedge just after the acceptance edge.
  task automatic start_txn(input logic [5:0] bc, input logic [1:0] mode, input logic dir,
                           input logic last, input logic [31:0] data);
    int n = 0;
    txnbc = bc; txnmode = mode; txndir = dir; txnlast = last; txndata = data;
    txnvalid = 1'b1;
    while (!txnready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (txnready_o !== 1'b1) begin
      $display("FAIL accept_wait: txnready_o=%b after %0d clocks, required 1", txnready_o, n);
      miscompares++;
    end
    @(negedge clk);
    txnvalid = 1'b0;
  endtask

  // Counts clocks to txndone_o, logs lanes at each SCK rise and plays a slave for reads.
  task automatic run_txn(input logic dir, input logic [1:0] mode, input logic [31:0] sdata,
                         input int scyc);
    int   l = 1 << mode;
    logic prev_sck = 1'b0;
    lat = 0; pulses = 0; oe_or = 0; oe_bad = 0; sce_low = 0; sio_or = 0;
    while (!txndone_o && lat < 300) begin
      if (sck_o && !prev_sck) begin
        if (pulses < 64) sio_log[pulses] = sio_o;
        if (sio_oe !== dir) oe_bad = 1'b1;
        if (!dir && pulses < scyc)
          sio_i = 8'((sdata >> (l * (scyc - 1 - pulses))) & ((32'd1 << l) - 32'd1));
        pulses++;
      end
      if (sio_oe) oe_or = 1'b1;
      if (sio_o != 8'd0) sio_or = 1'b1;
      if (!sce_o) sce_low = 1'b1;
      prev_sck = sck_o;
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (txndone_o !== 1'b1) begin
      $display("FAIL done_timeout: txndone_o=%b after %0d clocks, required 1", txndone_o, lat);
      miscompares++;
    end
    sio_i = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; txnvalid = 1'b0; sio_i = 8'h00;
    txnbc = '0; txnmode = '0; txndir = 1'b0; txnlast = 1'b0; txndata = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sck_o, sce_o, sio_o, sio_oe, txnready_o, txndone_o, txndata_o} !== 45'd0) begin
      $display("FAIL reset_outputs: sck=%b sce=%b sio=%h oe=%b rdy=%b done=%b data=%h, required all 0",
               sck_o, sce_o, sio_o, sio_oe, txnready_o, txndone_o, txndata_o);
      miscompares++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (txnready_o !== 1'b1 || sce_o !== 1'b0) begin
      $display("FAIL reset_release: rdy=%b sce=%b, required rdy=1 sce=0", txnready_o, sce_o);
      miscompares++;
    end
  endtask

  task automatic test_single_write();
    logic [7:0] b = 8'd0;
    logic       hi_lanes = 1'b0;
    start_txn(6'd8, 2'd0, 1'b1, 1'b1, 32'h0000_00A5);
    run_txn(1'b1, 2'd0, 32'd0, 0);
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], sio_log[i][0]};
      if (sio_log[i][7:1] != 7'd0) hi_lanes = 1'b1;
    end
    vectors++;
    if (lat != 34) begin $display("FAIL sw_latency: %0d clocks, required 34", lat); miscompares++; end
    vectors++;
    if (pulses != 8) begin $display("FAIL sw_pulses: %0d, required 8", pulses); miscompares++; end
    vectors++;
    if (b !== 8'hA5 || hi_lanes) begin
      $display("FAIL sw_bits: sio_o[0] sequence %h upper_lanes_used=%b, required a5 and 0", b, hi_lanes);
      miscompares++;
    end
    vectors++;
    if (oe_bad || sce_low) begin
      $display("FAIL sw_oe_sce: oe_bad=%b sce_low=%b, required 0 0", oe_bad, sce_low);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (sce_o !== 1'b1) begin $display("FAIL sw_csh_hold: sce=%b, required 1", sce_o); miscompares++; end
    @(negedge clk);
    vectors++;
    if (sce_o !== 1'b0) begin $display("FAIL sw_deselect: sce=%b, required 0", sce_o); miscompares++; end
    repeat (3) @(negedge clk);
    vectors++;
    if (txnready_o !== 1'b0) begin $display("FAIL sw_desel_busy: rdy=%b, required 0", txnready_o); miscompares++; end
    @(negedge clk);
    vectors++;
    if (txnready_o !== 1'b1) begin $display("FAIL sw_idle_ready: rdy=%b, required 1", txnready_o); miscompares++; end
  endtask

  task automatic test_quad_read();
    start_txn(6'd32, 2'd2, 1'b0, 1'b1, 32'd0);
    run_txn(1'b0, 2'd2, 32'hDEAD_BEEF, 8);
    vectors++;
    if (lat != 34 || pulses != 8) begin
      $display("FAIL qr_timing: lat=%0d pulses=%0d, required 34 8", lat, pulses);
      miscompares++;
    end
    vectors++;
    if (oe_or || sio_or) begin
      $display("FAIL qr_oe: oe_seen=%b sio_nonzero=%b, required 0 0", oe_or, sio_or);
      miscompares++;
    end
    vectors++;
    if (txndata_o !== 32'hDEAD_BEEF) begin
      $display("FAIL qr_data: txndata_o=%h, required deadbeef", txndata_o);
      miscompares++;
    end
  endtask

  task automatic test_zero_count();
    start_txn(6'd0, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_txn(1'b1, 2'd0, 32'd0, 0);
    vectors++;
    if (lat != 0 || txndata_o !== 32'hDEAD_BEEF) begin
      $display("FAIL zero_bc: lat=%0d data=%h, required 0 deadbeef", lat, txndata_o);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (txndone_o !== 1'b0 || sck_o !== 1'b0) begin
      $display("FAIL zero_bc_pulse: done=%b sck=%b, required 0 0", txndone_o, sck_o);
      miscompares++;
    end
  endtask

  task automatic test_odd_count();
    start_txn(6'd12, 2'd3, 1'b1, 1'b1, 32'h0000_0ABC);
    run_txn(1'b1, 2'd3, 32'd0, 0);
    vectors++;
    if (lat != 10 || pulses != 2) begin
      $display("FAIL odd_timing: lat=%0d pulses=%0d, required 10 2", lat, pulses);
      miscompares++;
    end
    vectors++;
    if (sio_log[0] !== 8'h0A || sio_log[1] !== 8'hBC) begin
      $display("FAIL odd_lanes: %h %h, required 0a bc", sio_log[0], sio_log[1]);
      miscompares++;
    end
  endtask

  task automatic test_clamp();
    start_txn(6'd40, 2'd3, 1'b1, 1'b1, 32'h89AB_CDEF);
    run_txn(1'b1, 2'd3, 32'd0, 0);
    vectors++;
    if (lat != 18 || pulses != 4) begin
      $display("FAIL clamp_timing: lat=%0d pulses=%0d, required 18 4", lat, pulses);
      miscompares++;
    end
    vectors++;
    if ({sio_log[0], sio_log[1], sio_log[2], sio_log[3]} !== 32'h89AB_CDEF) begin
      $display("FAIL clamp_lanes: %h%h%h%h, required 89abcdef", sio_log[0], sio_log[1], sio_log[2], sio_log[3]);
      miscompares++;
    end
  endtask

  task automatic test_chain();
    logic [7:0]  b = 8'd0;
    logic [23:0] q = 24'd0;
    start_txn(6'd8, 2'd0, 1'b1, 1'b0, 32'h0000_000B);
    run_txn(1'b1, 2'd0, 32'd0, 0);
    for (int i = 0; i < 8; i++) b = {b[6:0], sio_log[i][0]};
    vectors++;
    if (lat != 34 || b !== 8'h0B || sce_low) begin
      $display("FAIL chain_cmd: lat=%0d bits=%h sce_low=%b, required 34 0b 0", lat, b, sce_low);
      miscompares++;
    end
    vectors++;
    if ({sce_o, txnready_o, sck_o, sio_o, sio_oe} !== 12'b1100_0000_0000) begin
      $display("FAIL chain_hold: sce=%b rdy=%b sck=%b sio=%h oe=%b, required 1 1 0 00 0",
               sce_o, txnready_o, sck_o, sio_o, sio_oe);
      miscompares++;
    end
    start_txn(6'd24, 2'd2, 1'b1, 1'b0, 32'h0012_3456);
    run_txn(1'b1, 2'd2, 32'd0, 0);
    for (int i = 0; i < 6; i++) q = {q[19:0], sio_log[i][3:0]};
    vectors++;
    if (lat != 24 || pulses != 6 || q !== 24'h123456 || sce_low) begin
      $display("FAIL chain_addr: lat=%0d pulses=%0d nibbles=%h sce_low=%b, required 24 6 123456 0",
               lat, pulses, q, sce_low);
      miscompares++;
    end
    start_txn(6'd32, 2'd3, 1'b0, 1'b1, 32'd0);
    run_txn(1'b0, 2'd3, 32'hCAFE_F00D, 4);
    vectors++;
    if (lat != 16 || pulses != 4 || sce_low || oe_or) begin
      $display("FAIL chain_read_timing: lat=%0d pulses=%0d sce_low=%b oe=%b, required 16 4 0 0",
               lat, pulses, sce_low, oe_or);
      miscompares++;
    end
    vectors++;
    if (txndata_o !== 32'hCAFE_F00D) begin
      $display("FAIL chain_read_data: txndata_o=%h, required cafef00d", txndata_o);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    logic prev = 1'b0;
    logic done_seen = 1'b0;
    int   p = 0;
    int   n = 0;
    start_txn(6'd8, 2'd0, 1'b1, 1'b1, 32'h0000_00FF);
    while (n < 100) begin
      if (sck_o && !prev) p++;
      if (txndone_o) done_seen = 1'b1;
      if (p == 3) break;
      prev = sck_o;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (p != 3 || sck_o !== 1'b1) begin
      $display("FAIL rm_reach_high: pulses=%0d sck=%b, required 3 1", p, sck_o);
      miscompares++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sck_o, sce_o, sio_o, sio_oe, txnready_o, txndone_o, txndata_o} !== 45'd0 || done_seen) begin
      $display("FAIL rm_abort: sck=%b sce=%b sio=%h oe=%b rdy=%b done=%b data=%h done_seen=%b, required all 0",
               sck_o, sce_o, sio_o, sio_oe, txnready_o, txndone_o, txndata_o, done_seen);
      miscompares++;
    end
    txnbc = 6'd8; txnmode = 2'd3; txndir = 1'b1; txnlast = 1'b1; txndata = 32'h0000_005A;
    txnvalid = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (txnready_o !== 1'b1 || sce_o !== 1'b0 || txndone_o !== 1'b0) begin
      $display("FAIL rm_release: rdy=%b sce=%b done=%b, required 1 0 0", txnready_o, sce_o, txndone_o);
      miscompares++;
    end
    @(negedge clk);
    txnvalid = 1'b0;
    vectors++;
    if (sce_o !== 1'b1 || txnready_o !== 1'b0) begin
      $display("FAIL rm_accept: sce=%b rdy=%b, required 1 0", sce_o, txnready_o);
      miscompares++;
    end
    run_txn(1'b1, 2'd3, 32'd0, 0);
    vectors++;
    if (lat != 6 || sio_log[0] !== 8'h5A) begin
      $display("FAIL rm_new_txn: lat=%0d lanes=%h, required 6 5a", lat, sio_log[0]);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_quad_read();
    test_zero_count();
    test_odd_count();
    test_clamp();
    test_chain();
    test_reset_mid();
    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
